// File: rtl/alu32_arbiter_if.sv
// Bundle of request, shared-ALU and response signals for the two-port
// ALU arbiter. slave is the arbiter's view, master the surrounding logic.
interface alu32_arbiter_if #(
  parameter int WIDTH = 32
);
  // Request side
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [2:0]       req_f0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [2:0]       req_f1;

  // Shared ALU side
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_f;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             alu_overflow;

  // Response side
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_a0, req_b0, req_f0, req_a1, req_b1, req_f1,
    input  alu_y, alu_zero, alu_overflow, rsp_ready,
    output req_ready, alu_a, alu_b, alu_f,
    output rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_overflow, rsp_err
  );

  modport master (
    output req_valid, req_a0, req_b0, req_f0, req_a1, req_b1, req_f1,
    output alu_y, alu_zero, alu_overflow, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_f,
    input  rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_overflow, rsp_err
  );
endinterface

// File: rtl/alu32_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// A granted request is registered onto the ALU inputs for one cycle, the
// result is captured and then offered on a valid/ready response channel.
// Illegal function codes skip the ALU and answer with rsp_err set.
module alu32_arbiter #(
  parameter int WIDTH     = 32,
  parameter bit INIT_PRIO = 1'b0
) (
  input logic             clk,
  input logic             reset_n,
  alu32_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             prio;
  logic [1:0]       grant;
  logic             win;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [2:0]       win_f;

  function automatic logic is_legal(input logic [2:0] f);
    case (f)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: is_legal = 1'b1;
      default:                                is_legal = 1'b0;
    endcase
  endfunction

  // One-hot grant in IDLE; ties resolved by the priority pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant = 2'b00;
    if (state == IDLE) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    win   = grant[1];
    win_a = win ? bus.req_a1 : bus.req_a0;
    win_b = win ? bus.req_b1 : bus.req_b0;
    win_f = win ? bus.req_f1 : bus.req_f0;
  end

  // Reset also masks the grant so req_ready reads 00 while reset_n is low.
  assign bus.req_ready = grant & {2{reset_n}};

  // Control FSM with registered ALU operands and response payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      prio             <= INIT_PRIO;
      bus.alu_a        <= '0;
      bus.alu_b        <= '0;
      bus.alu_f        <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= 1'b0;
      bus.rsp_y        <= '0;
      bus.rsp_zero     <= 1'b0;
      bus.rsp_overflow <= 1'b0;
      bus.rsp_err      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            prio       <= ~win;
            bus.rsp_id <= win;
            if (is_legal(win_f)) begin
              bus.alu_a <= win_a;
              bus.alu_b <= win_b;
              bus.alu_f <= win_f;
              state     <= EXEC;
            end else begin
              // Illegal code: the ALU is bypassed and its operand registers keep their values.
              bus.rsp_y        <= '0;
              bus.rsp_zero     <= 1'b0;
              bus.rsp_overflow <= 1'b0;
              bus.rsp_err      <= 1'b1;
              bus.rsp_valid    <= 1'b1;
              state            <= RESP;
            end
          end
        end
        EXEC: begin
          bus.rsp_y        <= bus.alu_y;
          bus.rsp_zero     <= bus.alu_zero;
          bus.rsp_overflow <= bus.alu_overflow;
          bus.rsp_err      <= 1'b0;
          bus.rsp_valid    <= 1'b1;
          state            <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed bench for alu32_arbiter: reset, contention, overflow/SLT,
// backpressure, illegal code and asynchronous reset during EXEC.
module tb_alu32_arbiter;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  alu32_arbiter_if #(.WIDTH(32)) bus ();

  alu32_arbiter #(.WIDTH(32), .INIT_PRIO(1'b0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU standing in for the shared external instance.
  logic [31:0] m_y;
  logic        m_ovf;
  always_comb begin
    m_y   = '0;
    m_ovf = 1'b0;
    case (bus.alu_f)
      3'b000: m_y = bus.alu_a & bus.alu_b;
      3'b001: m_y = bus.alu_a | bus.alu_b;
      3'b010: begin
        m_y   = bus.alu_a + bus.alu_b;
        m_ovf = (bus.alu_a[31] == bus.alu_b[31]) && (m_y[31] != bus.alu_a[31]);
      end
      3'b110: begin
        m_y   = bus.alu_a - bus.alu_b;
        m_ovf = (bus.alu_a[31] != bus.alu_b[31]) && (m_y[31] != bus.alu_a[31]);
      end
      3'b111: m_y = {31'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      default: m_y = '0;
    endcase
  end
  assign bus.alu_y        = m_y;
  assign bus.alu_zero     = (m_y == 32'd0);
  assign bus.alu_overflow = m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " alu_a"},     bus.alu_a, 32'd0);
    check({tag, " alu_b"},     bus.alu_b, 32'd0);
    check({tag, " alu_f"},     {29'd0, bus.alu_f}, 32'd0);
    check({tag, " rsp_y"},     bus.rsp_y, 32'd0);
    check({tag, " rsp_flags"}, {28'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_zero,
                                bus.rsp_overflow}, 32'd0);
    check({tag, " rsp_err"},   {31'd0, bus.rsp_err}, 32'd0);
    check({tag, " req_ready"}, {30'd0, bus.req_ready}, 32'd0);
  endtask

  // Watchdog: the directed sequence is short; never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset_n       = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_a0    = '0;
    bus.req_b0    = '0;
    bus.req_f0    = '0;
    bus.req_a1    = '0;
    bus.req_b1    = '0;
    bus.req_f1    = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #3;
    check_reset_values("reset");
    #9 reset_n = 1'b1;
    tick();

    // Contention with INIT_PRIO=0: grants alternate 0,1,0,1
    bus.req_valid = 2'b11;
    bus.req_a0 = 32'd3;         bus.req_b0 = 32'd3;         bus.req_f0 = 3'b110;
    bus.req_a1 = 32'h0000_00F0; bus.req_b1 = 32'h0000_000F; bus.req_f1 = 3'b001;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont%0d grant", i), {30'd0, bus.req_ready},
            (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      check($sformatf("cont%0d alu_f", i), {29'd0, bus.alu_f},
            (i % 2 == 0) ? 32'd6 : 32'd1);
      tick();
      check($sformatf("cont%0d valid", i), {31'd0, bus.rsp_valid}, 32'd1);
      check($sformatf("cont%0d id", i), {31'd0, bus.rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("cont%0d y", i), bus.rsp_y, (i % 2 == 0) ? 32'd0 : 32'h0000_00FF);
      check($sformatf("cont%0d zero", i), {31'd0, bus.rsp_zero}, (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    bus.req_valid = 2'b00;

    // Single ADD on port 0: 5 + 7
    bus.req_a0 = 32'd5; bus.req_b0 = 32'd7; bus.req_f0 = 3'b010;
    bus.req_valid = 2'b01;
    #1;
    check("add grant N", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 2'b00;
    check("add alu_a N+1", bus.alu_a, 32'd5);
    check("add alu_b N+1", bus.alu_b, 32'd7);
    check("add alu_f N+1", {29'd0, bus.alu_f}, 32'd2);
    check("add no valid N+1", {31'd0, bus.rsp_valid}, 32'd0);
    check("add no grant EXEC", {30'd0, bus.req_ready}, 32'd0);
    tick();
    check("add valid N+2", {31'd0, bus.rsp_valid}, 32'd1);
    check("add y", bus.rsp_y, 32'd12);
    check("add flags", {29'd0, bus.rsp_zero, bus.rsp_overflow, bus.rsp_err}, 32'd0);
    check("add id", {31'd0, bus.rsp_id}, 32'd0);
    tick();
    check("add valid drop", {31'd0, bus.rsp_valid}, 32'd0);

    // Overflow on port 1 (pointer now at port 1)
    bus.req_a1 = 32'h7FFF_FFFF; bus.req_b1 = 32'd1; bus.req_f1 = 3'b010;
    bus.req_valid = 2'b10;
    #1;
    check("ovf grant", {30'd0, bus.req_ready}, 32'd2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("ovf y", bus.rsp_y, 32'h8000_0000);
    check("ovf flag", {31'd0, bus.rsp_overflow}, 32'd1);
    check("ovf zero", {31'd0, bus.rsp_zero}, 32'd0);
    check("ovf id", {31'd0, bus.rsp_id}, 32'd1);
    tick();

    // SLT on port 0: -1 < 1
    bus.req_a0 = 32'hFFFF_FFFF; bus.req_b0 = 32'd1; bus.req_f0 = 3'b111;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("slt y", bus.rsp_y, 32'd1);
    check("slt ovf", {31'd0, bus.rsp_overflow}, 32'd0);
    tick();

    // Backpressure: port 1 AND, rsp_ready low for 5 RESP cycles
    bus.rsp_ready = 1'b0;
    bus.req_a1 = 32'hFF00_FF00; bus.req_b1 = 32'h0FF0_0FF0; bus.req_f1 = 3'b000;
    bus.req_valid = 2'b10;
    #1;
    check("bp grant", {30'd0, bus.req_ready}, 32'd2);
    tick();
    // Port 0 now queues an illegal request behind the held response.
    bus.req_a0 = 32'h0000_1234; bus.req_b0 = 32'h0000_5678; bus.req_f0 = 3'b100;
    bus.req_valid = 2'b11;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d valid", i), {31'd0, bus.rsp_valid}, 32'd1);
      check($sformatf("bp%0d y", i), bus.rsp_y, 32'h0F00_0F00);
      check($sformatf("bp%0d id", i), {31'd0, bus.rsp_id}, 32'd1);
      check($sformatf("bp%0d ready", i), {30'd0, bus.req_ready}, 32'd0);
      if (i < 4) tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp released", {31'd0, bus.rsp_valid}, 32'd0);

    // Illegal f=100 on port 0, granted right after the handshake
    check("ill grant", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    check("ill valid N+1", {31'd0, bus.rsp_valid}, 32'd1);
    check("ill err", {31'd0, bus.rsp_err}, 32'd1);
    check("ill y", bus.rsp_y, 32'd0);
    check("ill flags", {30'd0, bus.rsp_zero, bus.rsp_overflow}, 32'd0);
    check("ill id", {31'd0, bus.rsp_id}, 32'd0);
    check("ill alu_a kept", bus.alu_a, 32'hFF00_FF00);
    check("ill alu_b kept", bus.alu_b, 32'h0FF0_0FF0);
    check("ill alu_f kept", {29'd0, bus.alu_f}, 32'd0);
    tick();

    // Pointer moved to port 1 after the illegal grant
    bus.req_a0 = 32'd1;  bus.req_b0 = 32'd1;  bus.req_f0 = 3'b010;
    bus.req_a1 = 32'd10; bus.req_b1 = 32'd20; bus.req_f1 = 3'b010;
    bus.req_valid = 2'b11;
    #1;
    check("post-ill grant", {30'd0, bus.req_ready}, 32'd2);
    tick();
    check("rst exec alu_a", bus.alu_a, 32'd10);

    // Asynchronous reset in the middle of EXEC
    bus.req_valid = 2'b00;
    #3 reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    #2 reset_n = 1'b1;
    tick();
    check("rst no rsp 1", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    check("rst no rsp 2", {31'd0, bus.rsp_valid}, 32'd0);

    // First request after reset arbitrated from INIT_PRIO
    bus.req_valid = 2'b11;
    #1;
    check("rst grant", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("rst rsp y", bus.rsp_y, 32'd2);
    check("rst rsp id", {31'd0, bus.rsp_id}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
